// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the shared data-memory bus.
// A grant is held for the whole transaction, and a watchdog force-completes a hung transaction.
module mem_arbiter #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_M0_Addr,
    input  logic [XLEN-1:0] i_M0_Wd,
    input  logic [2:0]      i_M0_f3,
    input  logic            i_M0_Wen,
    input  logic            i_M0_MemRead,
    output logic [XLEN-1:0] o_M0_ReadData,
    output logic            o_M0_data_ready,
    output logic            o_M0_err,
    input  logic [XLEN-1:0] i_M1_Addr,
    input  logic [XLEN-1:0] i_M1_Wd,
    input  logic [2:0]      i_M1_f3,
    input  logic            i_M1_Wen,
    input  logic            i_M1_MemRead,
    output logic [XLEN-1:0] o_M1_ReadData,
    output logic            o_M1_data_ready,
    output logic            o_M1_err,
    output logic [XLEN-1:0] o_MEM_Addr,
    output logic [XLEN-1:0] o_MEM_Wd,
    output logic [2:0]      o_MEM_f3,
    output logic            o_MEM_Wen,
    output logic            o_MEM_MemRead,
    input  logic            i_MEM_data_ready,
    input  logic [XLEN-1:0] i_MEM_ReadData
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t             state, state_nxt;
    logic               last_grant, last_grant_nxt;
    logic [CNT_W-1:0]   wd_cnt, wd_cnt_nxt;
    logic               req0, req1;
    logic               sel, own_req, other_req, timeout;

    assign req0 = i_M0_Wen | i_M0_MemRead;
    assign req1 = i_M1_Wen | i_M1_MemRead;

    assign o_M0_ReadData = i_MEM_ReadData;
    assign o_M1_ReadData = i_MEM_ReadData;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wd_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            wd_cnt     <= wd_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        last_grant_nxt  = last_grant;
        wd_cnt_nxt      = wd_cnt;
        sel             = 1'b0;
        own_req         = 1'b0;
        other_req       = 1'b0;
        timeout         = 1'b0;
        o_MEM_Addr      = '0;
        o_MEM_Wd        = '0;
        o_MEM_f3        = '0;
        o_MEM_Wen       = 1'b0;
        o_MEM_MemRead   = 1'b0;
        o_M0_data_ready = 1'b0;
        o_M0_err        = 1'b0;
        o_M1_data_ready = 1'b0;
        o_M1_err        = 1'b0;

        case (state)
            IDLE: begin
                // On a tie, last_grant decides; it resets to 1 so M0 wins the first tie.
                if (req0 && (!req1 || last_grant)) begin
                    state_nxt      = GNT0;
                    last_grant_nxt = 1'b0;
                    wd_cnt_nxt     = '0;
                end else if (req1) begin
                    state_nxt      = GNT1;
                    last_grant_nxt = 1'b1;
                    wd_cnt_nxt     = '0;
                end
            end
            GNT0, GNT1: begin
                sel       = (state == GNT1);
                own_req   = sel ? req1 : req0;
                other_req = sel ? req0 : req1;
                timeout   = (wd_cnt == CNT_W'(TIMEOUT_CYCLES)) && !i_MEM_data_ready;

                o_MEM_Addr    = sel ? i_M1_Addr    : i_M0_Addr;
                o_MEM_Wd      = sel ? i_M1_Wd      : i_M0_Wd;
                o_MEM_f3      = sel ? i_M1_f3      : i_M0_f3;
                o_MEM_Wen     = sel ? i_M1_Wen     : i_M0_Wen;
                o_MEM_MemRead = sel ? i_M1_MemRead : i_M0_MemRead;

                if (!own_req) begin
                    state_nxt = IDLE;
                end else if (i_MEM_data_ready || timeout) begin
                    if (timeout) begin
                        o_MEM_Wen     = 1'b0;
                        o_MEM_MemRead = 1'b0;
                    end
                    if (sel) begin
                        o_M1_data_ready = 1'b1;
                        o_M1_err        = timeout;
                    end else begin
                        o_M0_data_ready = 1'b1;
                        o_M0_err        = timeout;
                    end
                    // The completing master is never re-granted here; only the other one can be.
                    if (other_req) begin
                        state_nxt      = sel ? GNT0 : GNT1;
                        last_grant_nxt = ~sel;
                        wd_cnt_nxt     = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    wd_cnt_nxt = wd_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected completions are queued as stimulus is driven,
// and a negedge monitor pops and checks them when a data_ready appears.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
    logic [2:0]  m0_f3, m1_f3;
    logic        m0_wen, m0_rd, m1_wen, m1_rd;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_rdy, m0_err, m1_rdy, m1_err;
    logic [31:0] mem_addr, mem_wd;
    logic [2:0]  mem_f3;
    logic        mem_wen, mem_rd;
    logic        mem_rdy;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        m;
        logic [31:0] d;
        logic        e;
    } rsp_t;
    rsp_t sb[$];

    mem_arbiter #(.XLEN(32), .TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_M0_Addr(m0_addr), .i_M0_Wd(m0_wd), .i_M0_f3(m0_f3),
        .i_M0_Wen(m0_wen), .i_M0_MemRead(m0_rd),
        .o_M0_ReadData(m0_rdata), .o_M0_data_ready(m0_rdy), .o_M0_err(m0_err),
        .i_M1_Addr(m1_addr), .i_M1_Wd(m1_wd), .i_M1_f3(m1_f3),
        .i_M1_Wen(m1_wen), .i_M1_MemRead(m1_rd),
        .o_M1_ReadData(m1_rdata), .o_M1_data_ready(m1_rdy), .o_M1_err(m1_err),
        .o_MEM_Addr(mem_addr), .o_MEM_Wd(mem_wd), .o_MEM_f3(mem_f3),
        .o_MEM_Wen(mem_wen), .o_MEM_MemRead(mem_rd),
        .i_MEM_data_ready(mem_rdy), .i_MEM_ReadData(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        rsp_t r;
        if (m0_rdy || m1_rdy) begin
            chk("one_rdy", {31'b0, m0_rdy & m1_rdy}, 32'd0);
            chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                r = sb.pop_front();
                chk("rsp_master", {31'b0, m1_rdy}, {31'b0, r.m});
                chk("rsp_data", m1_rdy ? m1_rdata : m0_rdata, r.d);
                chk("rsp_err", {31'b0, m1_rdy ? m1_err : m0_err}, {31'b0, r.e});
            end
        end else begin
            chk("err_no_rdy", {31'b0, m0_err | m1_err}, 32'd0);
        end
    end

    initial begin
        rst = 1'b1;
        m0_addr = '0; m0_wd = '0; m0_f3 = 3'd2; m0_wen = 1'b0; m0_rd = 1'b0;
        m1_addr = '0; m1_wd = '0; m1_f3 = 3'd2; m1_wen = 1'b0; m1_rd = 1'b0;
        mem_rdy = 1'b0; mem_rdata = '0;

        tick(); tick();
        #1;
        chk("rst_memrd", {31'b0, mem_rd}, 32'd0);
        chk("rst_wen", {31'b0, mem_wen}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);

        // M1 read with a 3-cycle memory response
        tick(); rst = 1'b0; m1_addr = 32'h100; m1_rd = 1'b1;
        #1 chk("t1_lat0", {31'b0, mem_rd}, 32'd0);
        tick(); #1;
        chk("t1_rd", {31'b0, mem_rd}, 32'd1);
        chk("t1_addr", mem_addr, 32'h100);
        tick(); #1 chk("t1_rd2", {31'b0, mem_rd}, 32'd1);
        tick(); sb.push_back('{m: 1'b1, d: 32'hDEADBEEF, e: 1'b0});
        mem_rdata = 32'hDEADBEEF; mem_rdy = 1'b1;
        #1 chk("t1_rdy", {31'b0, m1_rdy}, 32'd1);
        tick(); m1_rd = 1'b0; mem_rdy = 1'b0;
        #1 chk("t1_idle", {31'b0, mem_rd}, 32'd0);

        // Simultaneous requests: M0 first, then zero-bubble handoff to M1
        tick(); m0_addr = 32'h200; m0_rd = 1'b1; m1_addr = 32'h300; m1_wd = 32'hCAFE; m1_wen = 1'b1;
        #1 chk("t2_idle", {31'b0, mem_wen | mem_rd}, 32'd0);
        tick(); #1;
        chk("t2_g0_addr", mem_addr, 32'h200);
        chk("t2_g0_rd", {31'b0, mem_rd}, 32'd1);
        chk("t2_g0_wen", {31'b0, mem_wen}, 32'd0);
        sb.push_back('{m: 1'b0, d: 32'h11111111, e: 1'b0});
        mem_rdata = 32'h11111111; mem_rdy = 1'b1;
        tick(); m0_rd = 1'b0; mem_rdy = 1'b0;
        #1;
        chk("t2_g1_addr", mem_addr, 32'h300);
        chk("t2_g1_wen", {31'b0, mem_wen}, 32'd1);
        chk("t2_g1_wd", mem_wd, 32'hCAFE);
        chk("t2_g1_rd", {31'b0, mem_rd}, 32'd0);
        sb.push_back('{m: 1'b1, d: 32'h22222222, e: 1'b0});
        mem_rdata = 32'h22222222; mem_rdy = 1'b1;
        tick(); m1_wen = 1'b0; mem_rdy = 1'b0;
        #1 chk("t2_idle2", {31'b0, mem_wen | mem_rd}, 32'd0);

        // Continuous contention with single-cycle memory: strict alternation
        tick(); m0_addr = 32'h400; m0_rd = 1'b1; m1_addr = 32'h500; m1_rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(); #1;
            chk("t3_grant", mem_addr, (i % 2 == 1) ? 32'h500 : 32'h400);
            sb.push_back('{m: (i % 2 == 1), d: 32'hA000 + 32'(i), e: 1'b0});
            mem_rdata = 32'hA000 + 32'(i); mem_rdy = 1'b1;
        end
        tick(); m0_rd = 1'b0; m1_rd = 1'b0; mem_rdy = 1'b0;
        #1 chk("t3_abort_rdy", {31'b0, m0_rdy}, 32'd0);
        tick(); #1 chk("t3_idle", {31'b0, mem_rd}, 32'd0);

        // Watchdog timeout on an M0 write that memory never answers
        tick(); m0_addr = 32'h600; m0_wd = 32'h12345678; m0_wen = 1'b1; mem_rdata = '0;
        #1 chk("t4_idle", {31'b0, mem_wen}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            chk("t4_wen", {31'b0, mem_wen}, 32'd1);
            chk("t4_wd", mem_wd, 32'h12345678);
            chk("t4_nordy", {31'b0, m0_rdy}, 32'd0);
        end
        tick(); sb.push_back('{m: 1'b0, d: 32'h0, e: 1'b1});
        #1;
        chk("t4_to_wen", {31'b0, mem_wen}, 32'd0);
        chk("t4_to_rdy", {31'b0, m0_rdy}, 32'd1);
        chk("t4_to_err", {31'b0, m0_err}, 32'd1);
        tick(); #1 chk("t4_back_idle", {31'b0, mem_wen}, 32'd0);
        m0_wen = 1'b0;
        tick(); #1 chk("t4_idle2", {31'b0, mem_wen}, 32'd0);

        // M1 aborts while waiting; pending M0 is granted after one idle cycle
        tick(); m1_addr = 32'h700; m1_rd = 1'b1;
        tick(); #1;
        chk("t5_wait_rd", {31'b0, mem_rd}, 32'd1);
        chk("t5_wait_addr", mem_addr, 32'h700);
        tick(); m1_rd = 1'b0; m0_addr = 32'h800; m0_rd = 1'b1;
        #1;
        chk("t5_abort_rdy", {31'b0, m1_rdy | m1_err}, 32'd0);
        chk("t5_abort_rd", {31'b0, mem_rd}, 32'd0);
        tick(); #1;
        chk("t5_idle_addr", mem_addr, 32'd0);
        chk("t5_idle_rd", {31'b0, mem_rd}, 32'd0);
        tick(); #1;
        chk("t5_g0_addr", mem_addr, 32'h800);
        chk("t5_g0_rd", {31'b0, mem_rd}, 32'd1);
        sb.push_back('{m: 1'b0, d: 32'h33333333, e: 1'b0});
        mem_rdata = 32'h33333333; mem_rdy = 1'b1;
        tick(); m0_rd = 1'b0; mem_rdy = 1'b0;
        #1 chk("t5_idle2", {31'b0, mem_rd}, 32'd0);

        // Reset while M1 is waiting; a later tie goes to M0
        tick(); m1_addr = 32'h900; m1_wd = 32'hABCD; m1_wen = 1'b1;
        tick(); #1 chk("t6_wen", {31'b0, mem_wen}, 32'd1);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; m0_addr = 32'hA00; m0_rd = 1'b1;
        #1;
        chk("t6_rst_wen", {31'b0, mem_wen}, 32'd0);
        chk("t6_rst_rd", {31'b0, mem_rd}, 32'd0);
        tick(); #1;
        chk("t6_tie_addr", mem_addr, 32'hA00);
        sb.push_back('{m: 1'b0, d: 32'h44444444, e: 1'b0});
        mem_rdata = 32'h44444444; mem_rdy = 1'b1;
        tick(); m0_rd = 1'b0;
        #1;
        chk("t6_hand_addr", mem_addr, 32'h900);
        chk("t6_hand_wen", {31'b0, mem_wen}, 32'd1);
        sb.push_back('{m: 1'b1, d: 32'h55555555, e: 1'b0});
        mem_rdata = 32'h55555555;
        tick(); m1_wen = 1'b0; mem_rdy = 1'b0;
        #1 chk("t6_idle", {31'b0, mem_wen | mem_rd}, 32'd0);

        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter that shares the single data-memory bus (Addr/Wd/f3/Wen/MemRead, ReadData/data_ready) between master 0 (instruction fetch) and master 1 (d_mem load/store port).
- Round-robin grant, held for a whole transaction.
- Back-to-back handoff on completion.
- Watchdog timeout that completes a hung transaction with an error flag.

Parameters:
- XLEN, 32: address/data width.
- TIMEOUT_CYCLES, 255: cycles a granted transaction may wait for i_MEM_data_ready before forced completion. Must be >= 1.
- CNT_W, 8: watchdog counter width. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_M0_Addr  in  XLEN  master 0 address.
- i_M0_Wd  in  XLEN  master 0 write data.
- i_M0_f3  in  3  master 0 access size (funct3).
- i_M0_Wen  in  1  master 0 write request.
- i_M0_MemRead  in  1  master 0 read request.
- o_M0_ReadData  out  XLEN  read data to master 0.
- o_M0_data_ready  out  1  master 0 transaction complete.
- o_M0_err  out  1  master 0 transaction timed out; valid with ready.
- i_M1_Addr, i_M1_Wd, i_M1_f3, i_M1_Wen, i_M1_MemRead  in  as M0  master 1 request.
- o_M1_ReadData, o_M1_data_ready, o_M1_err  out  as M0  master 1 response.
- o_MEM_Addr  out  XLEN  to memory.
- o_MEM_Wd  out  XLEN  to memory.
- o_MEM_f3  out  3  to memory.
- o_MEM_Wen  out  1  to memory.
- o_MEM_MemRead  out  1  to memory.
- i_MEM_data_ready  in  1  memory completion.
- i_MEM_ReadData  in  XLEN  memory read data.

Behaviour:
- Request: reqN = i_MN_Wen | i_MN_MemRead. A master holds its request and payload stable until it sees its data_ready, then it may drop or re-issue.
- Register state: IDLE, GNT0, GNT1; last_grant (1 bit); wd_cnt (CNT_W bits).
- Reset: state=IDLE, last_grant=1 (M0 wins first tie), wd_cnt=0.
- Reset mid-transaction returns to IDLE immediately. The memory sees enables drop the cycle after reset is sampled.
- In IDLE, all o_MEM_* are 0 and all o_MN_data_ready/o_MN_err are 0.
- IDLE arbitration:
  - Only one req: grant it.
  - Both req: grant the master != last_grant.
  - Next state GNTn; last_grant<=n; wd_cnt<=0.
  - Grant latency: 1 cycle from request to memory enable.
- GNTn, memory side: o_MEM_Addr/Wd/f3/Wen/MemRead = master n's inputs (combinational mux).
- GNTn, completion: o_Mn_data_ready = i_MEM_data_ready (combinational). The other master's ready = 0.
- GNTn, watchdog: wd_cnt increments each cycle without i_MEM_data_ready.
- Completion (i_MEM_data_ready in GNTn):
  - If the other master requests: next state GNTother, last_grant<=other, wd_cnt<=0. Zero-bubble handoff.
  - Otherwise: IDLE.
  - The completing master is never re-granted in the completion cycle, even if its request is still high.
- Timeout (GNTn, wd_cnt==TIMEOUT_CYCLES, no i_MEM_data_ready):
  - o_Mn_data_ready=1 and o_Mn_err=1 for that cycle.
  - o_MEM_Wen=o_MEM_MemRead=0 that cycle.
  - Next state chosen as for completion.
- Ready and timeout in the same cycle: normal completion; err=0.
- Abort: if granted master n drops reqN while in GNTn (e.g. exception squash), go to IDLE next cycle. No ready, no err, memory enables follow the dropped inputs.
- o_M0_ReadData = o_M1_ReadData = i_MEM_ReadData (broadcast). Valid only with the owner's data_ready.
- o_MEM_Wen and o_MEM_MemRead are never both driven from different masters. Exactly one master's payload is visible at a time.
- Fairness: with both masters requesting continuously, grants strictly alternate 0,1,0,1.
- Throughput: with both requesting and 1-cycle memory, one completion per cycle after the first grant.

Test Plan:
- Reset, then M1 read at Addr=0x100, memory ready after 3 cycles with ReadData=0xDEADBEEF:
  - o_MEM_MemRead=1 starting 1 cycle after the request.
  - o_M1_data_ready pulses once with o_M1_ReadData=0xDEADBEEF.
  - o_M0_data_ready stays 0 throughout.
- Both masters request in the same cycle from reset:
  - M0 granted first.
  - On its ready, o_MEM_Addr switches to M1's address in the next cycle with no IDLE bubble.
  - Then M1 completes.
- Both request continuously with memory ready every cycle for 8 completions:
  - Grant sequence 0,1,0,1,0,1,0,1.
  - Neither master is ever granted twice in a row.
- TIMEOUT_CYCLES=4, M0 write of Wd=0x12345678 with memory never ready:
  - o_MEM_Wen high 4 cycles.
  - On the 5th granted cycle: o_M0_data_ready=1, o_M0_err=1, o_MEM_Wen=0.
  - State returns to IDLE.
- M1 granted and waiting; M1 drops its request (abort):
  - Arbiter is IDLE next cycle.
  - No ready or err to M1.
  - A pending M0 request is granted the following cycle.
- i_rst asserted while in GNT1 mid-wait:
  - Next cycle: o_MEM_Wen=o_MEM_MemRead=0 and last_grant=1.
  - A subsequent simultaneous request grants M0.
